dmi_arbiter: RTL and testbench
==============================

DMI_ARBITER -- requirements
Module: dmi_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1: cycles from the dmi_valid cycle to the cycle dmi_rdata is sampled; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mN_req_valid  input  1  requester N (N = 0, 1) has a DMI request pending.
REQ-005 mN_req_ready  output  1  arbiter accepts requester N's request this cycle.
REQ-006 mN_req_wr  input  1  request type: 1 = write, 0 = read.
REQ-007 mN_req_addr  input  7  DMI register address.
REQ-008 mN_req_wdata  input  32  write data; ignored for reads.
REQ-009 mN_resp_valid  output  1  one-cycle pulse: requester N's transaction has completed.
REQ-010 mN_resp_rdata  output  32  read data; valid while mN_resp_valid is high.
REQ-011 dmi_valid  output  1  one-cycle DMI strobe to the debug module.
REQ-012 dmi_wr / dmi_addr / dmi_wdata  output  1 / 7 / 32  DMI transaction fields.
REQ-013 dmi_rdata  input  32  DMI read data from the debug module.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 grant  output  1  index of the requester owning the current or most recent transaction.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; all outputs are registered except mN_req_ready.
REQ-017 IDLE, single requester valid: assert that requester's mN_req_ready combinationally that cycle.
REQ-018 IDLE, both requesters valid: assert ready for the requester not equal to last_grant (round-robin); only one ready is ever high.
REQ-019 Handshake (valid && ready) at cycle T: capture wr/addr/wdata, set grant and last_grant to the winner, go to ISSUE.
REQ-020 ISSUE (T+1): dmi_valid=1 with the captured fields; write -> RESP; read -> WAIT with the counter loaded to RD_LAT.
REQ-021 WAIT: decrement the counter each cycle; at the cycle T+1+RD_LAT, capture dmi_rdata and go to RESP.
REQ-022 RESP: pulse mN_resp_valid for the granted requester only, for exactly one cycle, then go to IDLE.
REQ-023 Response timing: read response at T+2+RD_LAT; write response at T+2 with mN_resp_rdata = 0.
REQ-024 mN_req_ready SHALL be 0 in every state except IDLE; at most one transaction is outstanding.
REQ-025 Requests arriving while busy stall until the next IDLE; the requester holds valid and fields stable.
REQ-026 A back-to-back request from the same requester is accepted in the IDLE cycle directly after its RESP, unless the other requester is also valid.
REQ-027 dmi_wr/addr/wdata hold their last values while dmi_valid = 0; dmi_valid is never high for two consecutive cycles.
REQ-028 mN_resp_rdata holds its value until the next response to that requester.

Reset
REQ-029 While reset is high: state = IDLE; counter = 0; last_grant = 1, so requester 0 wins the first contention; grant = 0.
REQ-030 While reset is high, all outputs SHALL be 0: dmi_valid, dmi_wr, dmi_addr, dmi_wdata, both resp_valid, both resp_rdata, busy.
REQ-031 Reset mid-transaction aborts it: no resp_valid is issued and dmi_valid is 0 on the following cycle.

Verification
REQ-032 m0 read addr 0x11, RD_LAT=1, dmi_rdata=0xDEADBEEF -> dmi_valid at T+1 with addr 0x11, wr 0; m0_resp_valid at T+3 with rdata 0xDEADBEEF.
REQ-033 m1 write addr 0x10, wdata 0x80000001 -> dmi_valid at T+1 with wr 1; m1_resp_valid at T+2 with rdata 0; m0_resp_valid never asserted.
REQ-034 Both requesters valid continuously, after reset -> grant order 0,1,0,1, and each dmi_valid carries the granted requester's address.
REQ-035 RD_LAT=4, m0 read -> busy for 6 cycles, m0_resp_valid at T+6, and rdata is sampled exactly at T+5 (bench changes dmi_rdata at T+4 and T+6).
REQ-036 Reset asserted at T+2 of a read -> no resp_valid, dmi_valid 0, busy 0 on the next cycle; the first post-reset contention goes to m0.
REQ-037 m1 request arrives mid-transaction of m0 -> m1_req_ready stays 0 until IDLE, then m1 is accepted in the IDLE cycle after m0's RESP.

Source files
------------

// File: rtl/dmi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmi_arbiter
// Description : Two-requester round-robin arbiter in front of a single DMI
//               port. One transaction outstanding at a time; fixed read
//               latency of RD_LAT cycles from the DMI strobe to read data.
// Revision    : 1.0 - initial release
// ============================================================================
module dmi_arbiter #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  // requester 0
  input  logic        m0_req_valid,
  output logic        m0_req_ready,
  input  logic        m0_req_wr,
  input  logic [6:0]  m0_req_addr,
  input  logic [31:0] m0_req_wdata,
  output logic        m0_resp_valid,
  output logic [31:0] m0_resp_rdata,
  // requester 1
  input  logic        m1_req_valid,
  output logic        m1_req_ready,
  input  logic        m1_req_wr,
  input  logic [6:0]  m1_req_addr,
  input  logic [31:0] m1_req_wdata,
  output logic        m1_resp_valid,
  output logic [31:0] m1_resp_rdata,
  // DMI side
  output logic        dmi_valid,
  output logic        dmi_wr,
  output logic [6:0]  dmi_addr,
  output logic [31:0] dmi_wdata,
  input  logic [31:0] dmi_rdata,
  // status
  output logic        busy,
  output logic        grant
);

  localparam logic [3:0] CNT_LOAD = 4'(RD_LAT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [3:0] cnt;
  logic       last_grant;
  logic       accept;
  logic       accept_m1;

  assign accept    = (m0_req_valid & m0_req_ready) | (m1_req_valid & m1_req_ready);
  assign accept_m1 = m1_req_valid & m1_req_ready;

  // Next-state logic and the combinational ready/arbitration decision.
  always_comb begin
    state_next   = state;
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
    case (state)
      IDLE: begin
        if (m0_req_valid && m1_req_valid) begin
          // Round-robin: the requester that did not win last time goes now.
          m0_req_ready = last_grant;
          m1_req_ready = ~last_grant;
        end else begin
          m0_req_ready = m0_req_valid;
          m1_req_ready = m1_req_valid;
        end
        if (reset) begin
          m0_req_ready = 1'b0;
          m1_req_ready = 1'b0;
        end
        if (m0_req_ready || m1_req_ready) state_next = ISSUE;
      end
      ISSUE:   state_next = dmi_wr ? RESP : WAIT;
      WAIT:    if (cnt == 4'd1) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Registered outputs, captured request fields, latency counter and grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt           <= 4'd0;
      last_grant    <= 1'b1;
      grant         <= 1'b0;
      busy          <= 1'b0;
      dmi_valid     <= 1'b0;
      dmi_wr        <= 1'b0;
      dmi_addr      <= 7'd0;
      dmi_wdata     <= 32'd0;
      m0_resp_valid <= 1'b0;
      m1_resp_valid <= 1'b0;
      m0_resp_rdata <= 32'd0;
      m1_resp_rdata <= 32'd0;
    end else begin
      dmi_valid     <= 1'b0;
      m0_resp_valid <= 1'b0;
      m1_resp_valid <= 1'b0;
      busy          <= (state_next != IDLE);

      // Handshake: latch the winner's fields; they drive DMI next cycle and
      // then hold until the following transaction.
      if (accept) begin
        grant      <= accept_m1;
        last_grant <= accept_m1;
        dmi_valid  <= 1'b1;
        dmi_wr     <= accept_m1 ? m1_req_wr    : m0_req_wr;
        dmi_addr   <= accept_m1 ? m1_req_addr  : m0_req_addr;
        dmi_wdata  <= accept_m1 ? m1_req_wdata : m0_req_wdata;
      end

      case (state)
        ISSUE: begin
          if (dmi_wr) begin
            // Writes complete immediately with zero read data.
            if (grant) begin
              m1_resp_valid <= 1'b1;
              m1_resp_rdata <= 32'd0;
            end else begin
              m0_resp_valid <= 1'b1;
              m0_resp_rdata <= 32'd0;
            end
          end else begin
            cnt <= CNT_LOAD;
          end
        end
        WAIT: begin
          // cnt reaches 1 exactly RD_LAT cycles after the DMI strobe.
          if (cnt == 4'd1) begin
            cnt <= 4'd0;
            if (grant) begin
              m1_resp_valid <= 1'b1;
              m1_resp_rdata <= dmi_rdata;
            end else begin
              m0_resp_valid <= 1'b1;
              m0_resp_rdata <= dmi_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmi_arbiter
// Description : Randomized self-checking bench for dmi_arbiter against a
//               transaction-level timing model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmi_arbiter;

  localparam int LAT  = 4;
  localparam int NCYC = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  v;
  logic [1:0]  wr;
  logic [6:0]  a  [2];
  logic [31:0] wd [2];
  logic [31:0] dmi_rdata;

  logic        m0_req_ready, m1_req_ready;
  logic        m0_resp_valid, m1_resp_valid;
  logic [31:0] m0_resp_rdata, m1_resp_rdata;
  logic        dmi_valid, dmi_wr;
  logic [6:0]  dmi_addr;
  logic [31:0] dmi_wdata;
  logic        busy, grant;

  always #5 clk = ~clk;

  dmi_arbiter #(.RD_LAT(LAT)) dut (
    .clk           (clk),
    .reset         (reset),
    .m0_req_valid  (v[0]),
    .m0_req_ready  (m0_req_ready),
    .m0_req_wr     (wr[0]),
    .m0_req_addr   (a[0]),
    .m0_req_wdata  (wd[0]),
    .m0_resp_valid (m0_resp_valid),
    .m0_resp_rdata (m0_resp_rdata),
    .m1_req_valid  (v[1]),
    .m1_req_ready  (m1_req_ready),
    .m1_req_wr     (wr[1]),
    .m1_req_addr   (a[1]),
    .m1_req_wdata  (wd[1]),
    .m1_resp_valid (m1_resp_valid),
    .m1_resp_rdata (m1_resp_rdata),
    .dmi_valid     (dmi_valid),
    .dmi_wr        (dmi_wr),
    .dmi_addr      (dmi_addr),
    .dmi_wdata     (dmi_wdata),
    .dmi_rdata     (dmi_rdata),
    .busy          (busy),
    .grant         (grant)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
  endtask

  // Transaction-level model: one outstanding transaction with absolute
  // cycle stamps for its DMI strobe, read-data sample and response.
  logic        active;
  int          t_acc, t_resp, t_who;
  logic        t_wr;
  logic [6:0]  t_addr;
  logic [31:0] t_wdata, t_rdcap;
  logic        last_g, e_grant, e_wr;
  logic [6:0]  e_addr;
  logic [31:0] e_wdata;
  logic [31:0] e_rdata [2];

  task automatic model_reset();
    active     = 1'b0;
    last_g     = 1'b1;
    e_grant    = 1'b0;
    e_wr       = 1'b0;
    e_addr     = 7'd0;
    e_wdata    = 32'd0;
    e_rdata[0] = 32'd0;
    e_rdata[1] = 32'd0;
  endtask

  initial begin
    int   acc, acc_prev, pv;
    logic rst_c;
    logic [1:0] e_rdy, e_rv;

    reset     = 1'b1;
    v         = 2'b00;
    wr        = 2'b00;
    a[0]      = 7'd0;  a[1]  = 7'd0;
    wd[0]     = 32'd0; wd[1] = 32'd0;
    dmi_rdata = 32'd0;
    t_acc = 0; t_resp = 0; t_who = 0; t_wr = 1'b0;
    t_addr = 7'd0; t_wdata = 32'd0; t_rdcap = 32'd0;
    model_reset();
    acc_prev = -1;

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      // Retire a finished transaction, then apply its visible effects.
      if (active && c > t_resp) active = 1'b0;
      if (active && c == t_acc + 1) begin
        e_grant = t_who[0];
        e_wr    = t_wr;
        e_addr  = t_addr;
        e_wdata = t_wdata;
      end
      if (active && c == t_resp) e_rdata[t_who] = t_wr ? 32'd0 : t_rdcap;

      // Stimulus for this cycle. First 200 cycles: both requesters always
      // valid (strict alternation expected); then sparser traffic + resets.
      rst_c     = (c < 3) || (c >= 200 && $urandom_range(0, 39) == 0);
      reset     = rst_c;
      dmi_rdata = $urandom();
      if (active && !t_wr && c == t_acc + 1 + LAT) t_rdcap = dmi_rdata;
      pv = (c < 200) ? 100 : 45;
      for (int n = 0; n < 2; n++) begin
        if (acc_prev == n) v[n] = 1'b0;
        if (!v[n] && $urandom_range(0, 99) < pv) begin
          v[n]  = 1'b1;
          wr[n] = 1'($urandom_range(0, 1));
          a[n]  = 7'($urandom());
          wd[n] = $urandom();
        end
      end

      // Arbitration decision of the model for this cycle.
      acc = -1;
      if (!rst_c && !active) begin
        if (v[0] && v[1]) acc = last_g ? 0 : 1;
        else if (v[0])    acc = 0;
        else if (v[1])    acc = 1;
      end
      e_rdy = (acc == 0) ? 2'b01 : (acc == 1) ? 2'b10 : 2'b00;
      e_rv  = 2'b00;
      if (active && c == t_resp) e_rv[t_who] = 1'b1;

      #3;
      check_eq("dmi_valid", 32'(dmi_valid), 32'(active && c == t_acc + 1));
      check_eq("dmi_wr",    32'(dmi_wr),    32'(e_wr));
      check_eq("dmi_addr",  32'(dmi_addr),  32'(e_addr));
      check_eq("dmi_wdata", dmi_wdata,      e_wdata);
      check_eq("busy",      32'(busy),      32'(active && c > t_acc));
      check_eq("grant",     32'(grant),     32'(e_grant));
      check_eq("m0_resp_valid", 32'(m0_resp_valid), 32'(e_rv[0]));
      check_eq("m1_resp_valid", 32'(m1_resp_valid), 32'(e_rv[1]));
      check_eq("m0_resp_rdata", m0_resp_rdata, e_rdata[0]);
      check_eq("m1_resp_rdata", m1_resp_rdata, e_rdata[1]);
      if (!rst_c) begin
        check_eq("m0_req_ready", 32'(m0_req_ready), 32'(e_rdy[0]));
        check_eq("m1_req_ready", 32'(m1_req_ready), 32'(e_rdy[1]));
      end

      // Commit the model for the edge that ends this cycle.
      if (acc >= 0) begin
        active  = 1'b1;
        t_acc   = c;
        t_who   = acc;
        t_wr    = wr[acc];
        t_addr  = a[acc];
        t_wdata = wd[acc];
        t_resp  = c + 2 + (wr[acc] ? 0 : LAT);
        last_g  = acc[0];
      end
      if (rst_c) model_reset();
      acc_prev = rst_c ? -1 : acc;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
